// File: rtl/alu_op_decoder.sv
// ID/EX ALU operation decoder: maps a MIPS instruction to a registered ALU opcode,
// shift amount and operand-B selects. Define ALU_DEC_ILLEGAL_EN to flag undecodable instructions.
module alu_op_decoder #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] instr,
  input  logic                  instr_valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic [3:0]            alu_opcode,
  output logic [4:0]            sa,
  output logic                  imm_sel,
  output logic                  imm_zext,
  output logic                  ex_valid,
  output logic                  illegal
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SRLV = 4'b1001;
  localparam logic [3:0] ALU_SRAV = 4'b1010;
  localparam logic [3:0] ALU_SLLV = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_ADDU = 4'b1101;
  localparam logic [3:0] ALU_SUBU = 4'b1110;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0] opc;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic       unused_instr_bits;

  assign opc   = instr[31:26];
  assign funct = instr[5:0];
  assign shamt = instr[10:6];
  assign unused_instr_bits = ^instr[25:11];

  logic       dec_ok;
  logic [3:0] dec_op;
  logic [4:0] dec_sa;
  logic       dec_imm_sel;
  logic       dec_zext;

  always_comb begin
    dec_ok      = 1'b1;
    dec_op      = ALU_ADD;
    dec_sa      = 5'd0;
    dec_imm_sel = 1'b0;
    dec_zext    = 1'b0;
    case (opc)
      OP_RTYPE: begin
        case (funct)
          6'h00: begin dec_op = ALU_SLL; dec_sa = shamt; end
          6'h02: begin dec_op = ALU_SRL; dec_sa = shamt; end
          6'h03: begin dec_op = ALU_SRA; dec_sa = shamt; end
          6'h04: dec_op = ALU_SLLV;
          6'h06: dec_op = ALU_SRLV;
          6'h07: dec_op = ALU_SRAV;
          6'h20: dec_op = ALU_ADD;
          6'h21: dec_op = ALU_ADDU;
          6'h22: dec_op = ALU_SUB;
          6'h23: dec_op = ALU_SUBU;
          6'h24: dec_op = ALU_AND;
          6'h25: dec_op = ALU_OR;
          6'h26: dec_op = ALU_XOR;
          6'h27: dec_op = ALU_NOR;
          6'h2A: dec_op = ALU_SLT;
          6'h2B: dec_op = ALU_SLTU;
          default: dec_ok = 1'b0;
        endcase
      end
      OP_ADDI:  begin dec_op = ALU_ADD;  dec_imm_sel = 1'b1; end
      OP_ADDIU: begin dec_op = ALU_ADDU; dec_imm_sel = 1'b1; end
      OP_SLTI:  begin dec_op = ALU_SLT;  dec_imm_sel = 1'b1; end
      OP_SLTIU: begin dec_op = ALU_SLTU; dec_imm_sel = 1'b1; end
      OP_ANDI:  begin dec_op = ALU_AND;  dec_imm_sel = 1'b1; dec_zext = 1'b1; end
      OP_ORI:   begin dec_op = ALU_OR;   dec_imm_sel = 1'b1; dec_zext = 1'b1; end
      OP_XORI:  begin dec_op = ALU_XOR;  dec_imm_sel = 1'b1; dec_zext = 1'b1; end
      // LUI reuses the shifter: zero-extended immediate shifted left by 16
      OP_LUI:   begin dec_op = ALU_SLL;  dec_sa = 5'd16; dec_imm_sel = 1'b1; dec_zext = 1'b1; end
      OP_LW,
      OP_SW:    begin dec_op = ALU_ADD;  dec_imm_sel = 1'b1; end
      OP_BEQ,
      OP_BNE:   dec_op = ALU_SUB;
      default:  dec_ok = 1'b0;
    endcase
  end

  logic [3:0] nxt_op;
  logic [4:0] nxt_sa;
  logic       nxt_imm_sel;
  logic       nxt_zext;
  logic       nxt_vld;
  logic       nxt_illegal;

  // Undecodable words become a bubble (flagged) or fall through as plain ADD
  always_comb begin
    nxt_op      = ALU_ADD;
    nxt_sa      = 5'd0;
    nxt_imm_sel = 1'b0;
    nxt_zext    = 1'b0;
    nxt_vld     = 1'b0;
    nxt_illegal = 1'b0;
    if (instr_valid) begin
      if (dec_ok) begin
        nxt_op      = dec_op;
        nxt_sa      = dec_sa;
        nxt_imm_sel = dec_imm_sel;
        nxt_zext    = dec_zext;
        nxt_vld     = 1'b1;
      end else begin
`ifdef ALU_DEC_ILLEGAL_EN
        nxt_illegal = 1'b1;
`else
        nxt_vld     = 1'b1;
`endif
      end
    end
  end

  // ---- stage p1: ID/EX register ----
  logic [3:0] op_p1;
  logic [4:0] sa_p1;
  logic       imm_sel_p1;
  logic       zext_p1;
  logic       vld_p1;
  logic       illegal_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      op_p1      <= ALU_ADD;
      sa_p1      <= 5'd0;
      imm_sel_p1 <= 1'b0;
      zext_p1    <= 1'b0;
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
    end else if (!stall) begin
      op_p1      <= nxt_op;
      sa_p1      <= nxt_sa;
      imm_sel_p1 <= nxt_imm_sel;
      zext_p1    <= nxt_zext;
      vld_p1     <= nxt_vld;
      illegal_p1 <= nxt_illegal;
    end
  end

  assign alu_opcode = op_p1;
  assign sa         = sa_p1;
  assign imm_sel    = imm_sel_p1;
  assign imm_zext   = zext_p1;
  assign ex_valid   = vld_p1;
  assign illegal    = illegal_p1;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder; expectations follow ALU_DEC_ILLEGAL_EN when defined.
module tb_alu_op_decoder;

  typedef struct packed {
    logic [3:0] op;
    logic [4:0] sa;
    logic       imm_sel;
    logic       imm_zext;
    logic       ex_valid;
    logic       illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid, stall, flush;
  logic [3:0]  alu_opcode;
  logic [4:0]  sa;
  logic        imm_sel, imm_zext, ex_valid, illegal;

  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];
  exp_t cur_exp;

  localparam exp_t BUBBLE = '{op: 4'b0010, sa: 5'd0, imm_sel: 1'b0, imm_zext: 1'b0,
                              ex_valid: 1'b0, illegal: 1'b0};

  alu_op_decoder #(.WORD_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .alu_opcode(alu_opcode), .sa(sa),
    .imm_sel(imm_sel), .imm_zext(imm_zext), .ex_valid(ex_valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_val({tag, ".op"},       32'(alu_opcode), 32'(e.op));
    check_val({tag, ".sa"},       32'(sa),         32'(e.sa));
    check_val({tag, ".imm_sel"},  32'(imm_sel),    32'(e.imm_sel));
    check_val({tag, ".imm_zext"}, 32'(imm_zext),   32'(e.imm_zext));
    check_val({tag, ".ex_valid"}, 32'(ex_valid),   32'(e.ex_valid));
    check_val({tag, ".illegal"},  32'(illegal),    32'(e.illegal));
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic [4:0] s,
                              input logic isel, input logic zx);
    exp_t e;
    e = '{op: op, sa: s, imm_sel: isel, imm_zext: zx, ex_valid: 1'b1, illegal: 1'b0};
    return e;
  endfunction

  // Reference decode built from the opcode/funct tables
  function automatic exp_t ref_decode(input logic [31:0] w);
    logic [5:0] o;
    logic [5:0] f;
    logic [4:0] sh;
    exp_t e;
    logic ok;
    o = w[31:26]; f = w[5:0]; sh = w[10:6];
    ok = 1'b1;
    e = mk(4'b0010, 5'd0, 1'b0, 1'b0);
    if (o == 6'h00) begin
      case (f)
        6'h00: e = mk(4'b0100, sh, 1'b0, 1'b0);
        6'h02: e = mk(4'b0101, sh, 1'b0, 1'b0);
        6'h03: e = mk(4'b1000, sh, 1'b0, 1'b0);
        6'h04: e = mk(4'b1011, 5'd0, 1'b0, 1'b0);
        6'h06: e = mk(4'b1001, 5'd0, 1'b0, 1'b0);
        6'h07: e = mk(4'b1010, 5'd0, 1'b0, 1'b0);
        6'h20: e = mk(4'b0010, 5'd0, 1'b0, 1'b0);
        6'h21: e = mk(4'b1101, 5'd0, 1'b0, 1'b0);
        6'h22: e = mk(4'b0110, 5'd0, 1'b0, 1'b0);
        6'h23: e = mk(4'b1110, 5'd0, 1'b0, 1'b0);
        6'h24: e = mk(4'b0000, 5'd0, 1'b0, 1'b0);
        6'h25: e = mk(4'b0001, 5'd0, 1'b0, 1'b0);
        6'h26: e = mk(4'b0011, 5'd0, 1'b0, 1'b0);
        6'h27: e = mk(4'b1100, 5'd0, 1'b0, 1'b0);
        6'h2A: e = mk(4'b0111, 5'd0, 1'b0, 1'b0);
        6'h2B: e = mk(4'b1111, 5'd0, 1'b0, 1'b0);
        default: ok = 1'b0;
      endcase
    end else begin
      case (o)
        6'h08: e = mk(4'b0010, 5'd0, 1'b1, 1'b0);
        6'h09: e = mk(4'b1101, 5'd0, 1'b1, 1'b0);
        6'h0A: e = mk(4'b0111, 5'd0, 1'b1, 1'b0);
        6'h0B: e = mk(4'b1111, 5'd0, 1'b1, 1'b0);
        6'h0C: e = mk(4'b0000, 5'd0, 1'b1, 1'b1);
        6'h0D: e = mk(4'b0001, 5'd0, 1'b1, 1'b1);
        6'h0E: e = mk(4'b0011, 5'd0, 1'b1, 1'b1);
        6'h0F: e = mk(4'b0100, 5'd16, 1'b1, 1'b1);
        6'h23, 6'h2B: e = mk(4'b0010, 5'd0, 1'b1, 1'b0);
        6'h04, 6'h05: e = mk(4'b0110, 5'd0, 1'b0, 1'b0);
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
`ifdef ALU_DEC_ILLEGAL_EN
      e = BUBBLE;
      e.illegal = 1'b1;
`else
      e = mk(4'b0010, 5'd0, 1'b0, 1'b0);
`endif
    end
    return e;
  endfunction

  // Drive one cycle at the falling edge, push the expectation, compare after the rising edge
  task automatic step(input string tag, input logic [31:0] w, input logic v,
                      input logic st, input logic fl);
    exp_t e;
    @(negedge clk);
    instr = w; instr_valid = v; stall = st; flush = fl;
    if (fl)       cur_exp = BUBBLE;
    else if (!st) cur_exp = v ? ref_decode(w) : BUBBLE;
    sb_q.push_back(cur_exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s.queue: got=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      check_outputs(tag, e);
    end
  endtask

  logic [31:0] table_w [0:27] = '{
    32'h34A5_00FF, 32'h38A5_F0F0, 32'h28A5_8000, 32'h2CA5_0001, 32'h24A5_FFFF, 32'h20A5_7FFF,
    32'h8C85_0010, 32'hAC85_0010, 32'h1085_0004, 32'h1485_FFFC, 32'h0005_1000, 32'h0005_17C2,
    32'h0085_1004, 32'h0085_1006, 32'h0085_1007, 32'h0085_1021, 32'h0085_1023, 32'h0085_1024,
    32'h0085_1025, 32'h0085_1026, 32'h0085_1027, 32'h0085_102A, 32'h0085_102B, 32'h0800_0010,
    32'h0085_1001, 32'hFC00_0000, 32'h0085_1008, 32'h0005_1FC3
  };

  logic [5:0] rnd_ops [0:15] = '{
    6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B,
    6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02
  };

  initial begin
    exp_t rst_e;
    logic [31:0] w;
    reset = 1'b1; instr = 32'h0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    cur_exp = BUBBLE;
    #2;
    check_outputs("reset", BUBBLE);
    @(negedge clk);
    reset = 1'b0;

    step("add",  32'h0085_1020, 1'b1, 1'b0, 1'b0);
    step("sra",  32'h0005_1083, 1'b1, 1'b0, 1'b0);
    check_val("sra.sa_direct", 32'(sa), 32'd2);
    step("lui",  32'h3C01_1234, 1'b1, 1'b0, 1'b0);
    check_val("lui.sa_direct", 32'(sa), 32'd16);
    step("andi", 32'h3084_FFFF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("stall_hold", 32'h0085_1022, 1'b1, 1'b1, 1'b0);
    check_val("stall.op_direct", 32'(alu_opcode), 32'h0);
    step("stall_release", 32'h0085_1022, 1'b1, 1'b0, 1'b0);
    check_val("release.op_direct", 32'(alu_opcode), 32'h6);
    step("stall_flush", 32'h0085_1020, 1'b1, 1'b1, 1'b1);
    step("invalid", 32'h0085_1020, 1'b0, 1'b0, 1'b0);
    step("illegal", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
`ifdef ALU_DEC_ILLEGAL_EN
    check_val("illegal.flag_direct", 32'(illegal), 32'd1);
`else
    check_val("illegal.flag_direct", 32'(illegal), 32'd0);
`endif
    step("flush", 32'h0085_1020, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 28; i++)
      step($sformatf("tbl%0d", i), table_w[i], 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      w[31:26] = rnd_ops[$urandom_range(0, 15)];
      if (w[31:26] == 6'h00 && $urandom_range(0, 3) != 0)
        w[5:0] = table_w[$urandom_range(10, 22)][5:0];
      step("rand", w, ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0));
    end

    // Reset pulse between edges while a valid op is held by stall
    step("pre_rst", 32'h0085_1020, 1'b1, 1'b0, 1'b0);
    step("pre_rst_hold", 32'h0085_1022, 1'b1, 1'b1, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    rst_e = BUBBLE;
    check_outputs("async_rst", rst_e);
    #1;
    reset = 1'b0;
    cur_exp = BUBBLE;
    step("post_rst_stall", 32'h0085_1022, 1'b1, 1'b1, 1'b0);
    step("post_rst_load", 32'h0085_1022, 1'b1, 1'b0, 1'b0);

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
